// File: rtl/rsa_modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer for byte RSA: result = plain^exponent mod modulus,
// with every modular product delegated to an external Montgomery multiplier.
module rsa_modexp_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] plain,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] mont_r2,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result,
  output logic [2:0]       state_dbg
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [IW-1:0]    TOP = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TO_M   = 3'd1,
    S_TO_ONE = 3'd2,
    S_SQR    = 3'd3,
    S_MUL    = 3'd4,
    S_NEXT   = 3'd5,
    S_FROM   = 3'd6,
    S_DRAIN  = 3'd7
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] e_r;
  logic [WIDTH-1:0] r2_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] m_mont;
  logic [IW-1:0]    bit_idx;
  logic             pending;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             outstanding_now;

  assign state_dbg = state;

  // Multiplier handshake: mm_start is a one-cycle launch; mm_a/mm_b/mm_n are registers that only
  // change on a launch, so they stay stable until the matching mm_done pulse has been consumed.
  // pending marks a launched product whose mm_done has not yet been seen.
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state)
      S_TO_M:   begin op_a = m_r; op_b = r2_r; end
      S_TO_ONE: begin op_a = ONE; op_b = r2_r; end
      S_SQR:    begin op_a = acc; op_b = acc;  end
      S_MUL:    begin op_a = acc; op_b = m_mont; end
      S_FROM:   begin op_a = acc; op_b = ONE;  end
      default:  begin op_a = '0;  op_b = '0;   end
    endcase
  end

  // A product whose mm_done lands in the same cycle as stop needs no drain.
  assign outstanding_now = pending && !mm_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_n     <= '0;
      m_r      <= '0;
      e_r      <= '0;
      r2_r     <= '0;
      acc      <= '0;
      m_mont   <= '0;
      bit_idx  <= '0;
      pending  <= 1'b0;
    end else begin
      mm_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !stop) begin
            if (!modulus[0]) begin
              error <= 1'b1;
              done  <= 1'b0;
            end else begin
              m_r   <= plain;
              e_r   <= exponent;
              r2_r  <= mont_r2;
              mm_n  <= modulus;
              done  <= 1'b0;
              error <= 1'b0;
              busy  <= 1'b1;
              state <= S_TO_M;
            end
          end
        end

        S_DRAIN: begin
          if (mm_done) begin
            pending <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          if (stop) begin
            done    <= 1'b0;
            pending <= outstanding_now;
            busy    <= outstanding_now;
            state   <= outstanding_now ? S_DRAIN : S_IDLE;
          end else if (state == S_NEXT) begin
            if (bit_idx == '0) begin
              state <= S_FROM;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= S_SQR;
            end
          end else if (!pending) begin
            mm_start <= 1'b1;
            mm_a     <= op_a;
            mm_b     <= op_b;
            pending  <= 1'b1;
          end else if (mm_done) begin
            pending <= 1'b0;
            unique case (state)
              S_TO_M: begin
                m_mont <= mm_result;
                state  <= S_TO_ONE;
              end
              S_TO_ONE: begin
                acc     <= mm_result;
                bit_idx <= TOP;
                state   <= S_SQR;
              end
              S_SQR: begin
                acc   <= mm_result;
                state <= e_r[bit_idx] ? S_MUL : S_NEXT;
              end
              S_MUL: begin
                acc   <= mm_result;
                state <= S_NEXT;
              end
              S_FROM: begin
                result <= mm_result;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= S_IDLE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Bench for rsa_modexp_sequencer: behavioural Montgomery multiplier with variable latency,
// arithmetic modpow reference, and a done-triggered scoreboard.
module tb_rsa_modexp_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] plain = '0;
  logic [W-1:0] exponent = '0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] mont_r2 = '0;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] result;
  logic         mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_n;
  logic         mm_done = 1'b0;
  logic [W-1:0] mm_result = '0;
  logic [2:0]   state_dbg;

  rsa_modexp_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .plain(plain), .exponent(exponent), .modulus(modulus), .mont_r2(mont_r2),
    .busy(busy), .done(done), .error(error), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_result(mm_result), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic [W-1:0] exp_q[$];
  int           cnt_q[$];
  int           mm_starts = 0;
  int           lat = 3;
  int           op_base = 0;
  logic [W-1:0] last_exp = '0;

  task automatic check(input string name, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference arithmetic
  function automatic int mont(input int a, input int b, input int n);
    int p;
    if (n <= 0) return 0;
    p = (a * b) % n;
    for (int x = 0; x < n; x++)
      if (((x << W) % n) == p) return x;
    return 0;
  endfunction

  function automatic int modpow(input int m, input int e, input int n);
    int r;
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * m) % n;
    return r;
  endfunction

  function automatic int popcount(input int e);
    int c = 0;
    for (int k = 0; k < W; k++) c += (e >> k) & 1;
    return c;
  endfunction

  function automatic int r2_of(input int n);
    if (n <= 0) return 0;
    return (1 << (2 * W)) % n;
  endfunction

  // Montgomery multiplier model; also checks operand stability and single-outstanding launches
  initial begin : mult_model
    int           k;
    bit           out_m;
    logic [W-1:0] ca, cb, cn;
    k = 0; out_m = 0; ca = '0; cb = '0; cn = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (!rst_n) begin
        out_m = 0;
      end else begin
        if (out_m) begin
          check("mm_operands_stable", {mm_a, mm_b, mm_n}, {ca, cb, cn});
          k--;
          if (k == 0) begin
            mm_done   = 1'b1;
            mm_result = W'(mont(int'(ca), int'(cb), int'(cn)));
            out_m     = 0;
          end
        end
        if (mm_start) begin
          mm_starts++;
          check("no_overlapping_mm_start", out_m, 0);
          ca = mm_a; cb = mm_b; cn = mm_n;
          k = lat;
          out_m = 1;
        end
      end
    end
  end

  // Scoreboard monitor: a rising done retires one expected result
  initial begin : monitor
    logic         prev_done;
    logic [W-1:0] e;
    int           c;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !prev_done) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: result %0d with no operation outstanding", result);
        end else begin
          e = exp_q.pop_front();
          c = cnt_q.pop_front();
          check("result", result, e);
          check("mm_start_count", mm_starts, c);
          check("busy_low_at_done", busy, 0);
        end
      end
      prev_done = done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input int m, input int e, input int n, input int r2);
    @(negedge clk);
    plain = W'(m); exponent = W'(e); modulus = W'(n); mont_r2 = W'(r2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_op(input int m, input int e, input int n, input int l, input bit push);
    lat = l;
    op_base = mm_starts;
    if (push) begin
      exp_q.push_back(W'(modpow(m, e, n)));
      cnt_q.push_back(mm_starts + 3 + W + popcount(e));
      last_exp = W'(modpow(m, e, n));
    end
    pulse_start(m, e, n, r2_of(n));
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_clears_in_time", busy, 0);
    @(negedge clk);
  endtask

  task automatic run_op(input int m, input int e, input int n, input int l);
    begin_op(m, e, n, l, 1'b1);
    wait_idle();
  endtask

  task automatic wait_mults(input int target);
    int cyc = 0;
    while (mm_starts < target && cyc < 2000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("reached_multiply", mm_starts, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_mm_start"}, mm_start, 0);
    check({tag, "_mm_a"}, mm_a, 0);
    check({tag, "_mm_b"}, mm_b, 0);
    check({tag, "_mm_n"}, mm_n, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin : main
    int cnt0, n, m, e;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op(5, 3, 33, 2);
    check("m5_e3_n33", result, 26);
    check("done_after_op", done, 1);
    run_op(4, 0, 33, 5);
    check("e0_gives_one", result, 1);
    run_op(4, 255, 33, 8);

    // Even modulus is rejected without touching the multiplier
    cnt0 = mm_starts;
    pulse_start(7, 3, 32, 0);
    check("even_n_error", error, 1);
    check("even_n_done_cleared", done, 0);
    check("even_n_not_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("even_n_no_multiply", mm_starts, cnt0);
    pulse_start(9, 9, 0, 0);
    check("zero_n_error", error, 1);
    begin_op(9, 200, 35, 3, 1'b1);
    check("valid_start_clears_error", error, 0);
    check("valid_start_busy", busy, 1);
    wait_idle();

    // Stop while the third multiply is outstanding: drain, then idle
    begin_op(10, 77, 51, 6, 1'b0);
    check("valid_start_clears_done", done, 0);
    wait_mults(op_base + 3);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    begin
      int cyc = 0;
      while (!mm_done && cyc < 20) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("drain_saw_mm_done", mm_done, 1);
      check("busy_through_drain", busy, 1);
    end
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result_kept", result, last_exp);
    check("abort_state_idle", state_dbg, 0);
    check("abort_no_more_multiplies", mm_starts, op_base + 3);
    run_op(12, 201, 77, 4);

    // Stop before the first launch: nothing outstanding, idle next cycle
    begin_op(3, 5, 7, 2, 1'b0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("early_stop_idle", busy, 0);
    repeat (12) @(negedge clk);
    check("early_stop_no_multiply", mm_starts, op_base);
    check("early_stop_result_kept", result, last_exp);

    // Start while busy is ignored and operand inputs may change mid-run
    begin_op(17, 123, 101, 3, 1'b1);
    repeat (5) @(negedge clk);
    plain = W'($urandom); exponent = W'($urandom); modulus = 8'd64; mont_r2 = W'($urandom);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    plain = W'($urandom); modulus = W'($urandom);
    wait_idle();
    check("busy_start_no_error", error, 0);

    // Start and stop together while busy: stop wins
    begin_op(2, 99, 45, 5, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    wait_idle();
    check("start_stop_abort_done", done, 0);
    check("start_stop_result_kept", result, last_exp);

    // Start and stop together in idle: nothing happens
    cnt0 = mm_starts;
    @(negedge clk);
    plain = 8'd1; exponent = 8'd1; modulus = 8'd3; mont_r2 = 8'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("idle_start_stop_not_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("idle_start_stop_no_multiply", mm_starts, cnt0);

    // Reset during the first squaring
    begin_op(6, 170, 91, 7, 1'b0);
    wait_mults(op_base + 3);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(0, 13, 1, 2);
    check("n_one_result", result, 0);

    // Randomized operations
    for (int t = 0; t < 12; t++) begin
      n = int'($urandom_range(0, 127)) * 2 + 1;
      m = int'($urandom_range(0, n - 1));
      e = int'($urandom_range(0, 255));
      run_op(m, e, n, int'($urandom_range(1, 8)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
